// File: rtl/perspective_divide_seq_if.sv
// Vertex in, divider request/response and pixel out bundle
// for the perspective divide sequencer.
interface perspective_divide_seq_if #(
  parameter int WIDTH = 16,
  parameter int HW    = 9,
  parameter int VW    = 8
);
  logic                    valid_in;
  logic                    ready_out;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    div_valid_out;
  logic signed [WIDTH-1:0] div_a_out;
  logic signed [WIDTH-1:0] div_b_out;
  logic                    div_busy_in;
  logic                    div_done_in;
  logic                    div_valid_in;
  logic                    div_zerodiv_in;
  logic                    div_overflow_in;
  logic signed [WIDTH-1:0] div_q_in;
  logic                    valid_out;
  logic                    ready_in;
  logic [HW-1:0]           px_out;
  logic [VW-1:0]           py_out;
  logic                    culled_out;

  modport master (
    input  valid_in, x_in, y_in, z_in,
    input  div_busy_in, div_done_in, div_valid_in,
    input  div_zerodiv_in, div_overflow_in, div_q_in,
    input  ready_in,
    output ready_out, div_valid_out, div_a_out, div_b_out,
    output valid_out, px_out, py_out, culled_out
  );

  modport slave (
    output valid_in, x_in, y_in, z_in,
    output div_busy_in, div_done_in, div_valid_in,
    output div_zerodiv_in, div_overflow_in, div_q_in,
    output ready_in,
    input  ready_out, div_valid_out, div_a_out, div_b_out,
    input  valid_out, px_out, py_out, culled_out
  );
endinterface

// File: rtl/perspective_divide_seq.sv
// Sequences x/z then y/z through a shared divider and maps
// the quotients to clamped, cull-flagged pixel coordinates.
module perspective_divide_seq #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 14,
  parameter int HALF_W    = 160,
  parameter int HALF_H    = 90,
  parameter int HW        = $clog2(2*HALF_W),
  parameter int VW        = $clog2(2*HALF_H)
) (
  input logic clk_in,
  input logic rst_n_in,
  perspective_divide_seq_if.master bus
);

  localparam int PW = 2*WIDTH;
  localparam logic signed [PW-1:0] HW_C  = PW'(HALF_W);
  localparam logic signed [PW-1:0] HH_C  = PW'(HALF_H);
  localparam logic signed [PW-1:0] X_MAX = PW'(2*HALF_W-1);
  localparam logic signed [PW-1:0] Y_MAX = PW'(2*HALF_H-1);

  typedef enum logic [2:0] {
    IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, MAP, OUT
  } state_t;

  state_t state, next;

  logic signed [WIDTH-1:0] y_q, qx_q, qy_q, a_q, b_q;
  logic [HW-1:0] px_q, px_map;
  logic [VW-1:0] py_q, py_map;
  logic culled_q, ready_q, valid_q;
  logic cull_x, cull_y;
  logic accept, issue, div_fail, z_bad;
  logic signed [PW-1:0] prod_x, prod_y, sx, sy;

  assign z_bad    = bus.z_in[WIDTH-1] || (bus.z_in == '0);
  assign accept   = (state == IDLE) && bus.valid_in && ready_q;
  assign issue    = ((state == ISSUE_X) || (state == ISSUE_Y))
                    && !bus.div_busy_in;
  assign div_fail = bus.div_zerodiv_in || bus.div_overflow_in
                    || !bus.div_valid_in;

  assign bus.ready_out     = ready_q;
  assign bus.div_valid_out = issue;
  assign bus.div_a_out     = a_q;
  assign bus.div_b_out     = b_q;
  assign bus.valid_out     = valid_q;
  assign bus.px_out        = px_q;
  assign bus.py_out        = py_q;
  assign bus.culled_out    = culled_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = z_bad ? OUT : ISSUE_X;
      ISSUE_X: if (issue) next = WAIT_X;
      WAIT_X:  if (bus.div_done_in) next = div_fail ? OUT : ISSUE_Y;
      ISSUE_Y: if (issue) next = WAIT_Y;
      WAIT_Y:  if (bus.div_done_in) next = div_fail ? OUT : MAP;
      MAP:     next = OUT;
      OUT:     if (valid_q && bus.ready_in) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Screen y grows downward, hence the subtraction for sy.
  always_comb begin
    prod_x = PW'(qx_q) * HW_C;
    prod_y = PW'(qy_q) * HH_C;
    sx     = (prod_x >>> FRAC_BITS) + HW_C;
    sy     = HH_C - (prod_y >>> FRAC_BITS);
    px_map = sx[HW-1:0];
    py_map = sy[VW-1:0];
    cull_x = 1'b0;
    cull_y = 1'b0;
    if (sx[PW-1]) begin
      px_map = '0;
      cull_x = 1'b1;
    end else if (sx > X_MAX) begin
      px_map = HW'(2*HALF_W-1);
      cull_x = 1'b1;
    end
    if (sy[PW-1]) begin
      py_map = '0;
      cull_y = 1'b1;
    end else if (sy > Y_MAX) begin
      py_map = VW'(2*HALF_H-1);
      cull_y = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      culled_q <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      y_q      <= '0;
      qx_q     <= '0;
      qy_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      ready_q <= (next == IDLE);
      if (accept) begin
        y_q      <= bus.y_in;
        a_q      <= bus.x_in;
        b_q      <= bus.z_in;
        culled_q <= z_bad;
        px_q     <= '0;
        py_q     <= '0;
      end
      if ((state == WAIT_X) && bus.div_done_in) begin
        if (div_fail) culled_q <= 1'b1;
        else begin
          qx_q <= bus.div_q_in;
          a_q  <= y_q;
        end
      end
      if ((state == WAIT_Y) && bus.div_done_in) begin
        if (div_fail) culled_q <= 1'b1;
        else          qy_q     <= bus.div_q_in;
      end
      if (state == MAP) begin
        px_q     <= px_map;
        py_q     <= py_map;
        culled_q <= cull_x || cull_y;
      end
      // Result appears one cycle after entering OUT.
      if ((state == OUT) && !valid_q)      valid_q <= 1'b1;
      else if (valid_q && bus.ready_in)    valid_q <= 1'b0;
    end
  end

endmodule
